// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state codes,
// forwarding-select encodings and the E-stage result-select code for loads.
package hazard_pkg;

  // Memory-wait FSM state codes
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // E-stage operand forwarding selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_W   = 2'b01;

  // result_sgne value marking a load in E
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Pick the forwarding source for one E-stage operand; M is younger, so it wins over W
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] wr_m, input logic wen_m,
    input logic [4:0] wr_w, input logic wen_w
  );
    if (wen_m && (wr_m != 5'd0) && (wr_m == rs)) return FWD_M;
    if (wen_w && (wr_w != 5'd0) && (wr_w == rs)) return FWD_W;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: register addresses and control
// indications flow in, stall/flush/forward controls and stats flow out.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [4:0]       rs1_addrd, rs2_addrd;
  logic [4:0]       rs1_addre, rs2_addre, wr_addre;
  logic [1:0]       result_sgne;
  logic [4:0]       wr_addrm;
  logic             regwr_sgnm;
  logic [4:0]       wr_addrw;
  logic             regwr_sgnw;
  logic             pc_srce;
  logic             mem_reqm, mem_readym;

  logic             stallf, stalld, stalle, stallm;
  logic             flushd, flushe, flushw;
  logic [1:0]       fwd_ae, fwd_be;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Pipeline side
  modport master (
    output rs1_addrd, rs2_addrd, rs1_addre, rs2_addre, wr_addre, result_sgne,
           wr_addrm, regwr_sgnm, wr_addrw, regwr_sgnw, pc_srce, mem_reqm, mem_readym,
    input  stallf, stalld, stalle, stallm, flushd, flushe, flushw,
           fwd_ae, fwd_be, mem_err, stall_cnt, flush_cnt
  );

  // Hazard controller side
  modport slave (
    input  rs1_addrd, rs2_addrd, rs1_addre, rs2_addre, wr_addre, result_sgne,
           wr_addrm, regwr_sgnm, wr_addrw, regwr_sgnw, pc_srce, mem_reqm, mem_readym,
    output stallf, stalld, stalle, stallm, flushd, flushe, flushw,
           fwd_ae, fwd_be, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count qualifying cycles, hold at the maximum value
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: forwarding selects,
// load-use stall, branch flush, slow data-memory freeze with timeout, and
// saturating stall/flush statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] wait_cnt;
  logic       lw_stall, timeout, mem_wait;
  logic       stallf, stalld, stalle, stallm, flushd, flushe, flushw;

  // Operand forwarding for E; cleared while in reset
  always_comb begin
    hz.fwd_ae = rst ? FWD_REG : fwd_select(hz.rs1_addre, hz.wr_addrm, hz.regwr_sgnm,
                                           hz.wr_addrw, hz.regwr_sgnw);
    hz.fwd_be = rst ? FWD_REG : fwd_select(hz.rs2_addre, hz.wr_addrm, hz.regwr_sgnm,
                                           hz.wr_addrw, hz.regwr_sgnw);
  end

  // Hazard detection: load-use, memory timeout and memory freeze
  always_comb begin
    lw_stall = (hz.result_sgne == RES_LOAD) && (hz.wr_addre != 5'd0) &&
               ((hz.wr_addre == hz.rs1_addrd) || (hz.wr_addre == hz.rs2_addrd));
    timeout  = (state == ST_MEM_WAIT) && !hz.mem_readym && (wait_cnt == TIMEOUT_LAST);
    mem_wait = ((state == ST_RUN) && hz.mem_reqm && !hz.mem_readym) ||
               ((state == ST_MEM_WAIT) && !hz.mem_readym && !timeout);
  end

  // Prioritised stall/flush controls: rst > mem_wait > branch > load-use
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    stallf = 1'b0; stalld = 1'b0; stalle = 1'b0; stallm = 1'b0;
    flushd = 1'b0; flushe = 1'b0; flushw = 1'b0;
    if (rst) begin
      flushd = 1'b1; flushe = 1'b1; flushw = 1'b1;
    end else if (mem_wait) begin
      stallf = 1'b1; stalld = 1'b1; stalle = 1'b1; stallm = 1'b1;
      flushw = 1'b1;
    end else if (hz.pc_srce) begin
      flushd = 1'b1; flushe = 1'b1;
    end else if (lw_stall) begin
      stallf = 1'b1; stalld = 1'b1; flushe = 1'b1;
    end
  end

  assign hz.stallf = stallf;
  assign hz.stalld = stalld;
  assign hz.stalle = stalle;
  assign hz.stallm = stallm;
  assign hz.flushd = flushd;
  assign hz.flushe = flushe;
  assign hz.flushw = flushw;

  // Memory-wait FSM, wait-cycle counter and one-cycle timeout error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      hz.mem_err <= 1'b0;
    end else begin
      hz.mem_err <= timeout;
      if (state == ST_RUN) begin
        wait_cnt <= '0;
        if (hz.mem_reqm && !hz.mem_readym) state <= ST_MEM_WAIT;
      end else if (hz.mem_readym || timeout) begin
        state    <= ST_RUN;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stallf),
    .cnt (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flushe),
    .cnt (hz.flush_cnt)
  );

endmodule
